// File: rtl/rv32i_fetch_queue.sv
// RV32i instruction-fetch front end: one outstanding imem request, DEPTH-entry {instr,pc} FIFO, redirect flush.
// Optional same-cycle response bypass to decode when FETCHQ_BYPASS_EN is defined.
module rv32i_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       imem_req_o,
    output logic [XLEN-1:0]            imem_add_o,
    input  logic                       imem_valid_i,
    input  logic [31:0]                imem_data_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    input  logic                       stall_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [XLEN-1:0]            instr_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam int              PW   = $clog2(DEPTH);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [31:0]     NOP  = 32'h0000_0013;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_add;
    logic [31:0]     r_instr [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_resp;
    logic            w_empty;
    logic            w_bypass;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_issue_pc;
    logic [CW-1:0]   w_count_next;

    // A response only counts when it answers a live (non-stale) request and no redirect kills it.
    assign w_resp       = (r_state == S_WAIT) & imem_valid_i & !redirect_i;
    assign w_empty      = (r_count == '0);
`ifdef FETCHQ_BYPASS_EN
    assign w_bypass     = w_resp & w_empty;
`else
    assign w_bypass     = 1'b0;
`endif
    assign w_pop        = !w_empty & !redirect_i & !stall_i;
    assign w_push       = w_resp & !(w_bypass & !stall_i);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_pc_next    = r_fetch_pc + XLEN'(4);

    // Chained issue from WAIT uses post-push/pop occupancy; IDLE only needs a free slot now.
    assign w_issue      = !reset_i & !redirect_i &
                          (((r_state == S_IDLE) & (r_count < FULL)) |
                           (w_resp & (w_count_next < FULL)));
    assign w_issue_pc   = (r_state == S_WAIT) ? w_pc_next : r_fetch_pc;

    assign imem_req_o    = w_issue;
    assign imem_add_o    = w_issue ? w_issue_pc : r_add;
    assign count_o       = r_count;
    assign instr_valid_o = w_bypass | (!w_empty & !redirect_i);
    assign instr_o       = w_bypass ? imem_data_i :
                           (w_empty ? NOP : r_instr[r_rptr]);
    assign instr_pc_o    = w_bypass ? r_fetch_pc :
                           (w_empty ? '0 : r_pc[r_rptr]);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_add      <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_add <= w_issue_pc;
            end
            if (redirect_i) begin
                r_fetch_pc <= redirect_pc_i & ~XLEN'(3);
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
            end else begin
                if (w_resp) begin
                    r_fetch_pc <= w_pc_next;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                r_count <= w_count_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid_i) begin
                        r_state <= w_issue ? S_WAIT : S_IDLE;
                    end else if (redirect_i) begin
                        r_state <= S_FLUSH;
                    end
                end
                // The stale response still has to drain before a new request may go out.
                S_FLUSH: begin
                    if (imem_valid_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_instr[r_wptr] <= imem_data_i;
            r_pc[r_wptr]    <= r_fetch_pc;
        end
    end
endmodule
